// File: rtl/lane_sensor_hub_pkg.sv
// Shared lane constants, arbiter state type and the round-robin pick helper
// for lane_sensor_hub. Optional build macro: LANE_VIOLATION_EN.
package traffic_pkg;

  localparam int NUM_LANES = 8;
  localparam int LANE_W    = 8;

  localparam int LANE_N2 = 0;
  localparam int LANE_N1 = 1;
  localparam int LANE_E2 = 2;
  localparam int LANE_E1 = 3;
  localparam int LANE_S2 = 4;
  localparam int LANE_S1 = 5;
  localparam int LANE_W2 = 6;
  localparam int LANE_W1 = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } emg_state_t;

  // First requesting lane at or after last+1, wrapping; returns last+1 if none.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    rr_pick = last + 3'd1;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/lane_sensor_hub_if.sv
// Sensor-side and breadboard-side signal bundle of lane_sensor_hub.
// Inputs are level/pulse sampled each rising edge; there is no handshake.
interface lane_sensor_hub_if;
  import traffic_pkg::*;

  logic [7:0]  carArrive;
  logic [7:0]  carDepart;
  logic [7:0]  greenLanes;
  logic [7:0]  emgReq;
  logic [63:0] lanes;
  logic        emgSignal;
  logic [7:0]  emgLane;
  logic [2:0]  busiestLane;
  logic [10:0] totalCount;
  emg_state_t  emgState;
`ifdef LANE_VIOLATION_EN
  logic [7:0]  redRunFlag;
`endif

  modport slave (
    input  carArrive, carDepart, greenLanes, emgReq,
    output lanes, emgSignal, emgLane, busiestLane, totalCount, emgState
`ifdef LANE_VIOLATION_EN
    , output redRunFlag
`endif
  );

  modport master (
    output carArrive, carDepart, greenLanes, emgReq,
    input  lanes, emgSignal, emgLane, busiestLane, totalCount, emgState
`ifdef LANE_VIOLATION_EN
    , input redRunFlag
`endif
  );

endinterface

// File: rtl/lane_sensor_hub_lane_counter.sv
// One lane's saturating occupancy counter; departures only count on green
// and only when the lane is non-empty.
module lane_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arrive,
  input  logic         depart,
  input  logic         green,
  output logic [W-1:0] count
);

  logic dep_eff;
  logic at_max;

  assign dep_eff = depart && green && (count != '0);
  assign at_max  = (count == {W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (arrive && !dep_eff && !at_max) begin
      count <= count + 1'b1;
    end else if (dep_eff && !arrive) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lane_sensor_hub.sv
// Lane occupancy counters, busiest-lane/total reporting and round-robin
// emergency arbiter. Optional build macro: LANE_VIOLATION_EN (redRunFlag).
module lane_sensor_hub
  import traffic_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int CNT_W    = 8,
  parameter int EMG_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  lane_sensor_hub_if.slave  hub
);

  localparam int HW = (EMG_HOLD > 1) ? $clog2(EMG_HOLD) : 1;

  logic [CNT_W-1:0] cnt [LANES];
  logic [63:0]      lanes_flat;
  logic [2:0]       best_idx;
  logic [CNT_W-1:0] best_val;
  logic [10:0]      sum;
  logic [2:0]       busiest_q;
  logic [10:0]      total_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_counter #(.W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .arrive (hub.carArrive[i]),
      .depart (hub.carDepart[i]),
      .green  (hub.greenLanes[i]),
      .count  (cnt[i])
    );
  end

  // Strict '>' keeps the lowest index on ties and 0 when all counts are 0.
  always_comb begin
    lanes_flat = '0;
    best_idx   = '0;
    best_val   = cnt[0];
    sum        = '0;
    for (int i = 0; i < LANES; i++) begin
      lanes_flat[8*i +: 8] = cnt[i];
      sum = sum + 11'(cnt[i]);
      if (cnt[i] > best_val) begin
        best_val = cnt[i];
        best_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busiest_q <= '0;
      total_q   <= '0;
    end else begin
      busiest_q <= best_idx;
      total_q   <= sum;
    end
  end

  emg_state_t  state;
  logic [2:0]  grant;
  logic [2:0]  last_grant;
  logic [HW-1:0] hold_cnt;
  logic        sig_q;
  logic [7:0]  lane_q;
  logic [2:0]  pick;

  assign pick = rr_pick(hub.emgReq, last_grant);

  // A grant is never preempted; only its own request going low moves it on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 3'd7;
      hold_cnt   <= '0;
      sig_q      <= 1'b0;
      lane_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hub.emgReq != '0) begin
            grant  <= pick;
            state  <= GRANT;
            sig_q  <= 1'b1;
            lane_q <= 8'(1) << pick;
          end
        end
        GRANT: begin
          if (!hub.emgReq[grant]) begin
            if (EMG_HOLD == 0) begin
              state      <= IDLE;
              last_grant <= grant;
              sig_q      <= 1'b0;
              lane_q     <= '0;
            end else begin
              state    <= HOLD;
              hold_cnt <= HW'(EMG_HOLD - 1);
            end
          end
        end
        HOLD: begin
          if (hub.emgReq[grant]) begin
            state <= GRANT;
          end else if (hold_cnt == '0) begin
            state      <= IDLE;
            last_grant <= grant;
            sig_q      <= 1'b0;
            lane_q     <= '0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          sig_q  <= 1'b0;
          lane_q <= '0;
        end
      endcase
    end
  end

`ifdef LANE_VIOLATION_EN
  logic [7:0] red_q;
  always_ff @(posedge clk) begin
    if (rst) red_q <= '0;
    else     red_q <= red_q | (hub.carDepart & ~hub.greenLanes);
  end
  assign hub.redRunFlag = red_q;
`endif

  assign hub.lanes       = lanes_flat;
  assign hub.busiestLane = busiest_q;
  assign hub.totalCount  = total_q;
  assign hub.emgSignal   = sig_q;
  assign hub.emgLane     = lane_q;
  assign hub.emgState    = state;

endmodule

// File: tb/tb_lane_sensor_hub.sv
// Self-checking bench for lane_sensor_hub: directed scenarios plus random
// traffic against a counting model and a round-robin grant model.
module tb_lane_sensor_hub;
  import traffic_pkg::*;

  localparam int HOLD_CYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lane_sensor_hub_if hub ();

  lane_sensor_hub #(.LANES(8), .CNT_W(8), .EMG_HOLD(HOLD_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .hub (hub.slave)
  );

  int tests = 0;
  int fails = 0;

  int m_cnt [8];
  int exp_busy;
  int exp_total;
  logic [7:0] m_red;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_lanes();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(m_cnt[i]);
    return v;
  endfunction

  // Advance one clock, updating the model from the inputs as sampled at the edge.
  task automatic tick();
    int old [8];
    int b;
    for (int i = 0; i < 8; i++) old[i] = m_cnt[i];
    if (rst) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      exp_busy = 0; exp_total = 0; m_red = '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        int a, d;
        a = hub.carArrive[i] ? 1 : 0;
        d = (hub.carDepart[i] && hub.greenLanes[i] && old[i] > 0) ? 1 : 0;
        m_cnt[i] = old[i] + a - d;
        if (m_cnt[i] > 255) m_cnt[i] = 255;
        if (hub.carDepart[i] && !hub.greenLanes[i]) m_red[i] = 1'b1;
      end
      b = 0; exp_total = 0;
      for (int i = 0; i < 8; i++) begin
        exp_total += old[i];
        if (old[i] > old[b]) b = i;
      end
      exp_busy = b;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_lanes"}, hub.lanes, model_lanes());
    check({tag, "_busy"}, 64'(hub.busiestLane), 64'(exp_busy));
    check({tag, "_total"}, 64'(hub.totalCount), 64'(exp_total));
`ifdef LANE_VIOLATION_EN
    check({tag, "_red"}, 64'(hub.redRunFlag), 64'(m_red));
`endif
  endtask

  task automatic idle_inputs();
    hub.carArrive = '0; hub.carDepart = '0; hub.greenLanes = '0; hub.emgReq = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  int last;
  int g;
  logic [7:0] req;

  initial begin
    idle_inputs();
    m_red = '0;
    exp_busy = 0; exp_total = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;

    check_counts("reset");
    check("reset_sig", 64'(hub.emgSignal), 64'd0);
    check("reset_lane", 64'(hub.emgLane), 64'd0);
    check("reset_state", 64'(hub.emgState), 64'(IDLE));

    // Lane 3 up while red, then down on green past zero.
    hub.carArrive[3] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    hub.carArrive = '0;
    check("e1_up", 64'(hub.lanes[31:24]), 64'd5);
    hub.carDepart[3] = 1'b1; hub.greenLanes[3] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_counts("e1_down");
    end
    idle_inputs();
    check("e1_zero", 64'(hub.lanes[31:24]), 64'd0);

    // Tie between lanes 1 and 3.
    do_reset();
    hub.carArrive = 8'b0000_1010;
    for (int i = 0; i < 6; i++) tick();
    idle_inputs(); tick(); tick();
    check_counts("tie");
    check("tie_busy", 64'(hub.busiestLane), 64'd1);

    // Red-light departure on lane 0.
    do_reset();
    hub.carArrive[0] = 1'b1; tick(); tick(); idle_inputs();
    hub.carDepart[0] = 1'b1; tick(); idle_inputs(); tick();
    check("red_n2", 64'(hub.lanes[7:0]), 64'd2);
    check_counts("red");
`ifdef LANE_VIOLATION_EN
    check("red_flag", 64'(hub.redRunFlag), 64'h01);
`endif

    // Saturation of lane 7.
    do_reset();
    hub.carArrive[7] = 1'b1;
    for (int i = 0; i < 258; i++) tick();
    idle_inputs(); tick(); tick();
    check_counts("sat");
    check("sat_w1", 64'(hub.lanes[63:56]), 64'd255);
    check("sat_total", 64'(hub.totalCount), 64'd255);
    check("sat_busy", 64'(hub.busiestLane), 64'd7);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      hub.carArrive  = 8'($urandom);
      hub.carDepart  = 8'($urandom);
      hub.greenLanes = 8'($urandom) | 8'($urandom);
      tick();
      check_counts("rand");
    end
    idle_inputs();

    // Round-robin from reset with lanes 0 and 3 requesting.
    do_reset();
    hub.emgReq = 8'b0000_1001; tick();
    check("rr_first_lane", 64'(hub.emgLane), 64'h01);
    check("rr_first_sig", 64'(hub.emgSignal), 64'd1);
    tick(); tick();
    check("rr_noPreempt", 64'(hub.emgLane), 64'h01);
    hub.emgReq = 8'b0000_1000;
    for (int i = 0; i < HOLD_CYC; i++) begin
      tick();
      check("rr_hold_sig", 64'(hub.emgSignal), 64'd1);
      check("rr_hold_lane", 64'(hub.emgLane), 64'h01);
    end
    tick();
    check("rr_idle_sig", 64'(hub.emgSignal), 64'd0);
    check("rr_idle_lane", 64'(hub.emgLane), 64'd0);
    tick();
    check("rr_next_lane", 64'(hub.emgLane), 64'h08);

    // Reassert during hold keeps the same lane.
    hub.emgReq = 8'b0000_0000; tick();
    check("re_hold_state", 64'(hub.emgState), 64'(HOLD));
    hub.emgReq = 8'b0000_1001; tick();
    check("re_grant_state", 64'(hub.emgState), 64'(GRANT));
    check("re_grant_lane", 64'(hub.emgLane), 64'h08);

    // Reset mid-hold with nonzero counts.
    hub.carArrive = 8'hFF; tick(); hub.carArrive = '0;
    hub.emgReq = '0; tick();
    check("mh_in_hold", 64'(hub.emgState), 64'(HOLD));
    do_reset();
    check_counts("mh");
    check("mh_lanes0", hub.lanes, 64'd0);
    check("mh_sig", 64'(hub.emgSignal), 64'd0);
    check("mh_lane", 64'(hub.emgLane), 64'd0);
    check("mh_state", 64'(hub.emgState), 64'(IDLE));
    hub.emgReq = 8'b1000_0001; tick();
    check("mh_lastgrant", 64'(hub.emgLane), 64'h01);
    hub.emgReq = '0;
    for (int i = 0; i <= HOLD_CYC; i++) tick();

    // Random requests against a round-robin model.
    do_reset();
    last = 7;
    for (int n = 0; n < 25; n++) begin
      req = 8'($urandom_range(1, 255));
      hub.emgReq = req;
      g = -1;
      for (int k = 1; k <= 8; k++)
        if (g < 0 && req[(last + k) % 8]) g = (last + k) % 8;
      tick();
      check("rrr_lane", 64'(hub.emgLane), 64'(8'(1) << g));
      check("rrr_onehot", 64'($countones(hub.emgLane)), 64'd1);
      for (int h = $urandom_range(0, 4); h > 0; h--) begin
        hub.emgReq = 8'($urandom) | (8'(1) << g);
        tick();
        check("rrr_stable", 64'(hub.emgLane), 64'(8'(1) << g));
      end
      hub.emgReq = '0;
      for (int i = 0; i < HOLD_CYC; i++) begin
        tick();
        check("rrr_hold", 64'(hub.emgSignal), 64'd1);
      end
      tick();
      check("rrr_idle", 64'(hub.emgSignal), 64'd0);
      last = g;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lane_sensor_hub.md
# lane_sensor_hub

Upstream stage of the traffic-light breadboard. Turns per-lane arrival and departure pulses into the eight 8-bit lane occupancy counts the breadboard consumes, and arbitrates raw per-lane siren detections into the breadboard's single `emgSignal` / one-hot `emgLane` pair. It also reports the busiest lane for load-time selection.

## Interface
Parameters:
- `LANES`, 8: number of lanes; the packing below is fixed for 8.
- `CNT_W`, 8: width of each lane counter.
- `EMG_HOLD`, 4: cycles `emgSignal` stays high after the granted siren drops.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `carArrive`, in, 8: per-lane arrival pulse; bit i is lane i.
- `carDepart`, in, 8: per-lane departure pulse.
- `greenLanes`, in, 8: per-lane green light, driven from the breadboard's `dayTimeLightOutput`.
- `emgReq`, in, 8: per-lane siren detect, level.
- `lanes`, out, 64: packed counts `{w1,w2,s1,s2,e1,e2,n1,n2}`. Lane i is in `lanes[8i+7:8i]`, so n2 is lane 0 and w1 is lane 7.
- `emgSignal`, out, 1: emergency active.
- `emgLane`, out, 8: one-hot granted lane; zero when idle.
- `busiestLane`, out, 3: index of the largest count.
- `totalCount`, out, 11: sum of all lane counts.

## Operation
Lane counters:
- Next value per lane is `cnt + arrive − (depart & green)`.
- A departure while the lane is red is ignored.
- A departure while the count is 0 is ignored.
- Arrival and departure in the same cycle leave the count unchanged.
- Counts saturate at 255: an arrival at 255 with no counted departure holds 255.

Busiest lane:
- Registered from the current counts.
- Ties go to the lowest index.
- All-zero counts give 0.

Total count:
- Registered sum of the current counts; no overflow is possible at 11 bits.

Emergency arbiter (FSM states IDLE, GRANT, HOLD):
- IDLE → GRANT when `emgReq` is nonzero. The grant uses round-robin: the search starts at `(lastGrant+1) mod 8`, and `lastGrant` resets to 7, so the first search starts at lane 0. Record the granted index.
- GRANT: stay while `emgReq[grant]` is high. Other requests are ignored; there is no preemption. When it drops, go to HOLD and load the hold counter with `EMG_HOLD−1`.
- HOLD: if `emgReq[grant]` reasserts, return to GRANT with the same lane. Else decrement; at 0 go to IDLE and update `lastGrant`.
- `emgSignal` is 1 in GRANT and HOLD. `emgLane` is one-hot of the grant in GRANT and HOLD, and 0 in IDLE.
- With `EMG_HOLD = 0`, GRANT goes straight to IDLE.

Reset (including mid-grant or mid-hold):
- All counts 0, `busiestLane` 0, `totalCount` 0.
- FSM to IDLE, `emgSignal` 0, `emgLane` 0, `lastGrant` 7, hold counter 0.
- If `LANE_VIOLATION_EN` is defined, `redRunFlag` also 0.

## Timing
- Pulses sampled at edge N appear in `lanes` after edge N.
- `busiestLane` and `totalCount` reflect `lanes` one cycle later (2-cycle latency from the pulse).
- A request first seen high in IDLE at edge N gives `emgSignal` = 1 after edge N.
- After the request falls, `emgSignal` stays high for exactly `EMG_HOLD` cycles, then drops.
- Multiple simultaneous requests: exactly one bit of `emgLane` is ever set.

## Configuration
`LANE_VIOLATION_EN`:
- Defined: adds output `redRunFlag` [7:0]. Bit i is sticky-set when `carDepart[i]` is high while `greenLanes[i]` is 0, and is cleared only by `rst`. The counter behaviour is unchanged.
- Undefined: the port and its logic are absent.

## Structure
Shared package `traffic_pkg`:
- constants `NUM_LANES`, `LANE_W`;
- lane index constants `LANE_N2`…`LANE_W1` (0…7);
- FSM state typedef `emg_state_t` {IDLE, GRANT, HOLD}.

One sub-module, `lane_counter`, instantiated 8× via generate: a single saturating up/down counter with arrive, depart and green inputs. The arbiter, max-finder and sum stay in the top.

## Test plan
- **Reset mid-HOLD.** Hold `rst` 1 cycle while in HOLD → all outputs 0 the next cycle, FSM in IDLE.
- **Count up and down.** Pulse `carArrive[3]` for 5 cycles with lane 3 red → e1 = 5. Then `carDepart[3]` ×7 with `greenLanes[3]` = 1 → e1 = 0, no underflow.
- **Saturation.** Set w1 = 255 by 255 arrivals, then 3 more arrivals → w1 stays 255, `totalCount` = 255, `busiestLane` = 7.
- **Red-light departure.** `carDepart[0]` with `greenLanes[0]` = 0 and n2 = 2 → n2 stays 2. With `LANE_VIOLATION_EN` defined, `redRunFlag` = 8'b00000001.
- **Round-robin.** `emgReq` = 8'b00001001 from reset → `emgLane` = 8'b00000001. Drop bit 0, wait `EMG_HOLD` = 4 → next grant is 8'b00001000. `emgSignal` stays high through HOLD for 4 cycles.
- **Tie.** Counts n1 = e1 = 6 (lanes 1 and 3) → `busiestLane` = 1.
